// File: rtl/poker_pkg.sv
// Shared poker evaluator definitions: card layout, rank bounds,
// hand categories, accumulator types and straight detection.
package poker_pkg;

  localparam int NCARDS = 7;
  localparam int CARD_W = 6;
  localparam int HAND_W = NCARDS * CARD_W;
  localparam int RANK_LO = 0;
  localparam int RANK_HI = 3;
  localparam int SUIT_LO = 4;
  localparam int SUIT_HI = 5;
  localparam int NRANKS = 13;
  localparam int NSUITS = 4;

  localparam logic [3:0] RANK_MIN = 4'd2;
  localparam logic [3:0] RANK_ACE = 4'd14;

  typedef enum logic [3:0] {
    CAT_HIGH     = 4'd0,
    CAT_PAIR     = 4'd1,
    CAT_TWO_PAIR = 4'd2,
    CAT_TRIPS    = 4'd3,
    CAT_STRAIGHT = 4'd4,
    CAT_FLUSH    = 4'd5,
    CAT_FULL     = 4'd6,
    CAT_QUADS    = 4'd7,
    CAT_SFLUSH   = 4'd8
  } cat_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_CLASSIFY,
    S_DONE
  } state_e;

  typedef logic [NRANKS-1:0][2:0] hist_t;
  typedef logic [NSUITS-1:0][2:0] scnt_t;
  typedef logic [NSUITS-1:0][NRANKS-1:0] smask_t;

  // Bit i of m is rank i+2; returns top rank of best straight or 0.
  function automatic logic [3:0] straight_top(
    input logic [NRANKS-1:0] m
  );
    logic [3:0] t;
    t = '0;
    for (int i = NRANKS - 1; i >= 4; i--)
      if (t == '0 && (&m[i -: 5]))
        t = 4'(i) + RANK_MIN;
    if (t == '0 && m[NRANKS-1] && (&m[3:0]))
      t = 4'd5;
    return t;
  endfunction

endpackage

// File: rtl/hand_classify.sv
// Single-cycle hand classifier over the rank histogram,
// suit counts and per-suit rank masks.
module hand_classify
  import poker_pkg::*;
(
  input  hist_t       hist,
  input  scnt_t       scnt,
  input  smask_t      smask,
  input  logic        err_in,
  output logic [3:0]  cat,
  output logic [3:0]  hi,
  output logic [3:0]  lo,
  output logic        err
);

  logic [NRANKS-1:0] present;
  logic [NRANKS-1:0] fmask;
  logic              flush;
  logic [3:0]        r;
  logic [3:0]        quad_r;
  logic [3:0]        trip_r;
  logic [3:0]        pair1;
  logic [3:0]        pair2;
  logic [3:0]        top1;
  logic [3:0]        top2;
  logic [3:0]        fl_hi;
  logic [3:0]        st_hi;
  logic [3:0]        sf_hi;

  always_comb begin
    present = '0;
    fmask   = '0;
    flush   = 1'b0;
    r       = '0;
    quad_r  = '0;
    trip_r  = '0;
    pair1   = '0;
    pair2   = '0;
    top1    = '0;
    top2    = '0;
    fl_hi   = '0;
    for (int s = 0; s < NSUITS; s++)
      if (scnt[s] >= 3'd5) begin
        flush = 1'b1;
        fmask = smask[s];
      end
    // Walk ranks high to low so the first hit is the highest.
    for (int i = NRANKS - 1; i >= 0; i--) begin
      r = 4'(i) + RANK_MIN;
      present[i] = hist[i] != '0;
      if (hist[i] != '0) begin
        if (top1 == '0) top1 = r;
        else if (top2 == '0) top2 = r;
      end
      if (fmask[i] && fl_hi == '0) fl_hi = r;
      if (hist[i] == 3'd4) quad_r = r;
      else if (hist[i] == 3'd3 && trip_r == '0) trip_r = r;
      else if (hist[i] >= 3'd2) begin
        if (pair1 == '0) pair1 = r;
        else if (pair2 == '0) pair2 = r;
      end
    end
    st_hi = straight_top(present);
    sf_hi = flush ? straight_top(fmask) : '0;
  end

  always_comb begin
    cat = CAT_HIGH;
    hi  = '0;
    lo  = '0;
    err = err_in;
    if (err_in) begin
      cat = CAT_HIGH;
    end else if (sf_hi != '0) begin
      cat = CAT_SFLUSH;
      hi  = sf_hi;
    end else if (quad_r != '0) begin
      cat = CAT_QUADS;
      hi  = quad_r;
      lo  = (top1 == quad_r) ? top2 : top1;
    end else if (trip_r != '0 && pair1 != '0) begin
      cat = CAT_FULL;
      hi  = trip_r;
      lo  = pair1;
    end else if (flush) begin
      cat = CAT_FLUSH;
      hi  = fl_hi;
    end else if (st_hi != '0) begin
      cat = CAT_STRAIGHT;
      hi  = st_hi;
    end else if (trip_r != '0) begin
      cat = CAT_TRIPS;
      hi  = trip_r;
    end else if (pair2 != '0) begin
      cat = CAT_TWO_PAIR;
      hi  = pair1;
      lo  = pair2;
    end else if (pair1 != '0) begin
      cat = CAT_PAIR;
      hi  = pair1;
    end else begin
      cat = CAT_HIGH;
      hi  = top1;
    end
  end

endmodule

// File: rtl/hand_eval.sv
// Seven-card poker hand evaluator: latch, scan one card per
// cycle into accumulators, classify, then pulse done.
module hand_eval
  import poker_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [41:0] card_in,
  output logic        busy,
  output logic        done,
  output logic [3:0]  hand_cat,
  output logic [3:0]  hi_rank,
  output logic [3:0]  lo_rank,
  output logic        err
);

  localparam int TOP = HAND_W - CARD_W;

  state_e            state;
  state_e            state_n;
  logic [HAND_W-1:0] cards_q;
  logic [2:0]        idx;
  hist_t             hist;
  scnt_t             scnt;
  smask_t            smask;
  logic              err_q;

  logic [3:0] rank;
  logic [3:0] ri;
  logic [1:0] suit;
  logic       rank_ok;
  logic       dup;
  logic [3:0] c_cat;
  logic [3:0] c_hi;
  logic [3:0] c_lo;
  logic       c_err;

  assign rank    = cards_q[TOP+RANK_HI:TOP+RANK_LO];
  assign suit    = cards_q[TOP+SUIT_HI:TOP+SUIT_LO];
  assign ri      = rank - RANK_MIN;
  assign rank_ok = rank >= RANK_MIN && rank <= RANK_ACE;
  assign dup     = rank_ok && smask[suit][ri];
  assign busy    = state != S_IDLE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:     if (start) state_n = S_SCAN;
      S_SCAN:     if (idx == 3'(NCARDS - 1)) state_n = S_CLASSIFY;
      S_CLASSIFY: state_n = S_DONE;
      S_DONE:     state_n = S_IDLE;
      default:    state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cards_q  <= '0;
      idx      <= '0;
      hist     <= '0;
      scnt     <= '0;
      smask    <= '0;
      err_q    <= 1'b0;
      done     <= 1'b0;
      hand_cat <= '0;
      hi_rank  <= '0;
      lo_rank  <= '0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: if (start) begin
          cards_q <= card_in;
          idx     <= '0;
          hist    <= '0;
          scnt    <= '0;
          smask   <= '0;
          err_q   <= 1'b0;
        end
        S_SCAN: begin
          // Card 1 sits in the top slot; shift the next one up.
          cards_q <= cards_q << CARD_W;
          idx     <= idx + 3'd1;
          if (!rank_ok || dup) begin
            err_q <= 1'b1;
          end else begin
            hist[ri]        <= hist[ri] + 3'd1;
            scnt[suit]      <= scnt[suit] + 3'd1;
            smask[suit][ri] <= 1'b1;
          end
        end
        S_DONE: begin
          done     <= 1'b1;
          hand_cat <= c_cat;
          hi_rank  <= c_hi;
          lo_rank  <= c_lo;
          err      <= c_err;
        end
        default: ;
      endcase
    end
  end

  hand_classify u_classify (
    .hist   (hist),
    .scnt   (scnt),
    .smask  (smask),
    .err_in (err_q),
    .cat    (c_cat),
    .hi     (c_hi),
    .lo     (c_lo),
    .err    (c_err)
  );

endmodule

// File: doc/hand_eval.md
HAND_EVAL -- requirements
Module: hand_eval

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock, the block's only clock.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous and active-high.
REQ-003 SHALL have port: start  input  1  request to evaluate the cards on card_in.
REQ-004 SHALL have port: card_in  input  42  seven rank-sorted cards from the upstream sort stage; card 1 at [41:36], card 7 at [5:0]; each card is {suit[1:0], rank[3:0]}.
REQ-005 SHALL have port: busy  output  1  high while an evaluation is in progress.
REQ-006 SHALL have port: done  output  1  one-cycle pulse; result outputs are valid.
REQ-007 SHALL have port: hand_cat  output  4  hand category: 0 high card, 1 pair, 2 two pair, 3 trips, 4 straight, 5 flush, 6 full house, 7 quads, 8 straight flush.
REQ-008 SHALL have port: hi_rank  output  4  primary rank of the hand.
REQ-009 SHALL have port: lo_rank  output  4  secondary rank of the hand, 0 when unused.
REQ-010 SHALL have port: err  output  1  card set invalid.

Function
REQ-011 SHALL treat ranks 2..14 as valid (14 = ace) and ranks 0, 1 and 15 as invalid; suits 0..3 are all valid.
REQ-012 SHALL implement FSM IDLE -> SCAN -> CLASSIFY -> DONE -> IDLE.
REQ-013 SHALL, in IDLE on a clock edge with start=1, latch all of card_in, clear the accumulators, set busy and enter SCAN.
REQ-014 SHALL, in SCAN, process one card per cycle, card 1 first, for exactly 7 cycles; per card: increment the rank histogram (13 x 3 bits), the suit count (4 x 3 bits) and set the per-suit rank mask bit (4 x 13 bits).
REQ-015 SHALL set an internal error flag in SCAN when a card has an invalid rank or its per-suit mask bit is already set (duplicate card).
REQ-016 SHALL, in CLASSIFY, compute the result in one cycle using the highest-priority category per REQ-007 ordering.
REQ-017 SHALL set straight when five consecutive ranks are present, and SHALL also treat A-2-3-4-5 as a straight with hi_rank=5.
REQ-018 SHALL set flush when any suit count is 5 or more, and straight flush when that suit's rank mask alone contains a straight.
REQ-019 SHALL assign ranks per category:
  - straight and straight flush: hi = top card of the best straight.
  - quads: hi = quad rank; lo = highest other rank present.
  - full house: hi = highest trips; lo = highest other rank with count 2 or more.
  - flush: hi = highest rank in the flush suit.
  - trips: hi = trip rank.
  - two pair: hi and lo = two highest pair ranks.
  - pair: hi = pair rank.
  - high card: hi = highest rank.
REQ-020 SHALL, when the error flag is set, output hand_cat=0, hi_rank=0, lo_rank=0 and err=1.
REQ-021 SHALL register all results, pulse done for exactly one cycle in DONE, deassert busy in that same cycle, and then return to IDLE.
REQ-022 SHALL assert done 9 cycles after the start edge: start at edge N gives done high after edge N+9.
REQ-023 SHALL hold hand_cat, hi_rank, lo_rank and err stable from done until the next done.
REQ-024 SHALL ignore start in any state other than IDLE and SHALL never re-sample card_in mid-evaluation.
REQ-025 SHALL accept start in the cycle right after done, giving back-to-back evaluations 10 cycles apart.

Reset
REQ-026 SHALL, on rst=1 at any time including mid-evaluation, enter IDLE and clear all accumulators and the error flag immediately.
REQ-027 SHALL drive busy=0, done=0, hand_cat=0, hi_rank=0, lo_rank=0 and err=0 during reset.
REQ-028 SHALL begin the first evaluation no earlier than the first start edge after rst deasserts.

Structure
REQ-029 SHALL take the card field positions, rank bounds (RANK_MIN=2, RANK_ACE=14) and hand category constants from the shared package poker_pkg.
REQ-030 SHALL put the combinational CLASSIFY logic in one sub-module, hand_classify, which takes the histogram and masks and returns category and ranks.

Verification
REQ-031 SHALL cover, with suits given in parentheses:
  - Royal flush: A K Q J 10 all suit 0, plus 2(1), 3(2) -> hand_cat=8, hi=14, lo=0, done at start+9.
  - Wheel: A(0) 5(1) 4(2) 3(3) 2(0) 9(1) 7(2) -> hand_cat=4, hi=5.
  - Full house: K K K 9 9 9 2, mixed suits -> hand_cat=6, hi=13, lo=9.
  - Duplicate card: 6'h0E appears twice -> err=1, hand_cat=0, hi=0, lo=0.
  - Reset asserted in the 4th SCAN cycle -> busy=0, no done; the next start yields a correct result.
  - start held high for 20 cycles -> exactly two done pulses, 10 cycles apart.
